// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Write-side master for the 32x32 register file (x0 hard-wired to zero, one
// write port). Merges results from the single-cycle ALU and the load/store
// unit into that single write port. The ALU normally has priority. LSU results
// wait in a small FIFO. A starvation counter forces an LSU pop when the FIFO
// has been bypassed for too long.
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_alu_valid/o_alu_ready ALU result handshake
//   i_alu_rd, i_alu_data    ALU destination register and result
//   i_lsu_valid/o_lsu_ready LSU result handshake (ready = FIFO not full)
//   i_lsu_rd, i_lsu_data    LSU destination register and result
//   o_write_en              registered register-file write enable
//   o_selectW               registered register-file write select
//   o_portW                 registered register-file write data
//   o_pending               bit i set while a buffered LSU entry targets reg i
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [4:0]            i_alu_rd,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [4:0]            i_lsu_rd,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_write_en,
  output logic [4:0]            o_selectW,
  output logic [DATA_WIDTH-1:0] o_portW,
  output logic [31:0]           o_pending
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  // FIFO storage and bookkeeping
  logic [4:0]            fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]            fifo_rd_d   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Starvation control
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  force_lsu_q, force_lsu_d;

  // Registered write port
  logic                  write_en_q, write_en_d;
  logic [4:0]            select_q, select_d;
  logic [DATA_WIDTH-1:0] port_q, port_d;

  // Combinational control
  logic                  fifo_ne_s;
  logic                  lsu_push_s;
  logic                  alu_fire_s;
  logic                  pop_s;
  logic                  take_alu_s;
  logic [31:0]           pending_s;

  // Handshake readiness and fire conditions, all from registered state only
  always_comb begin
    fifo_ne_s   = (count_q != {CNT_W{1'b0}});
    o_lsu_ready = (count_q < DEPTH_C);
    o_alu_ready = ~force_lsu_q;
    lsu_push_s  = i_lsu_valid & o_lsu_ready;
    alu_fire_s  = i_alu_valid & ~force_lsu_q;
  end

  // Priority arbitration: forced LSU, then ALU, then any buffered LSU result
  always_comb begin
    pop_s      = 1'b0;
    take_alu_s = 1'b0;
    if (force_lsu_q && fifo_ne_s) begin
      pop_s = 1'b1;
    end else if (alu_fire_s) begin
      take_alu_s = 1'b1;
    end else if (fifo_ne_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s      = 1'b0;
      take_alu_s = 1'b0;
    end
  end

  // FIFO next state; push and pop may both happen in one cycle
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    fifo_vld_d  = fifo_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // Clear the head first so a push into the same slot (only possible when
    // the FIFO is not full, i.e. a different slot) is never masked.
    if (pop_s) begin
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (lsu_push_s) begin
      fifo_rd_d[wr_ptr_q]   = i_lsu_rd;
      fifo_data_d[wr_ptr_q] = i_lsu_data;
      fifo_vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({lsu_push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: counts cycles a non-empty FIFO is bypassed. Force is
  // raised on the same edge the counter reaches the limit, so the ALU sees
  // ready low in the very next cycle.
  always_comb begin
    starve_d    = starve_q;
    force_lsu_d = force_lsu_q;
    if (pop_s) begin
      starve_d    = {STV_W{1'b0}};
      force_lsu_d = 1'b0;
    end else if (!fifo_ne_s) begin
      starve_d    = {STV_W{1'b0}};
      force_lsu_d = 1'b0;
    end else if (starve_q != LIMIT_C) begin
      starve_d    = starve_q + STV_W'(1);
      force_lsu_d = force_lsu_q | (starve_q + STV_W'(1) == LIMIT_C);
    end else begin
      starve_d    = starve_q;
      force_lsu_d = 1'b1;
    end
  end

  // Output stage next state; select/data hold when idle, x0 never writes
  always_comb begin
    write_en_d = 1'b0;
    select_d   = select_q;
    port_d     = port_q;
    if (pop_s) begin
      write_en_d = (fifo_rd_q[rd_ptr_q] != 5'd0);
      select_d   = fifo_rd_q[rd_ptr_q];
      port_d     = fifo_data_q[rd_ptr_q];
    end else if (take_alu_s) begin
      write_en_d = (i_alu_rd != 5'd0);
      select_d   = i_alu_rd;
      port_d     = i_alu_data;
    end else begin
      write_en_d = 1'b0;
      select_d   = select_q;
      port_d     = port_q;
    end
  end

  // Pending-destination bitmap over valid FIFO entries, x0 masked
  always_comb begin
    pending_s = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pending_s[fifo_rd_q[i]] = pending_s[fifo_rd_q[i]] |
                                (fifo_vld_q[i] & (fifo_rd_q[i] != 5'd0));
    end
    pending_s[0] = 1'b0;
    o_pending    = pending_s;
  end

  // State registers; reset discards any buffered or staged results
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= 5'd0;
        fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
      end
      fifo_vld_q  <= {FIFO_DEPTH{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      starve_q    <= {STV_W{1'b0}};
      force_lsu_q <= 1'b0;
      write_en_q  <= 1'b0;
      select_q    <= 5'd0;
      port_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      fifo_vld_q  <= fifo_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      force_lsu_q <= force_lsu_d;
      write_en_q  <= write_en_d;
      select_q    <= select_d;
      port_q      <= port_d;
    end
  end

  // Registered write port drives the register file directly
  always_comb begin
    o_write_en = write_en_q;
    o_selectW  = select_q;
    o_portW    = port_q;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int DATA_WIDTH   = 32;

  logic        i_clk;
  logic        i_reset;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        o_write_en;
  logic [4:0]  o_selectW;
  logic [31:0] o_portW;
  logic [31:0] o_pending;

  writeback_arbiter #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_alu_valid(i_alu_valid),
    .o_alu_ready(o_alu_ready),
    .i_alu_rd   (i_alu_rd),
    .i_alu_data (i_alu_data),
    .i_lsu_valid(i_lsu_valid),
    .o_lsu_ready(o_lsu_ready),
    .i_lsu_rd   (i_lsu_rd),
    .i_lsu_data (i_lsu_data),
    .o_write_en (o_write_en),
    .o_selectW  (o_selectW),
    .o_portW    (o_portW),
    .o_pending  (o_pending)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: queue of buffered LSU results plus expected port values
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_dat;
  int          m_starve;
  logic        m_force;
  logic        alu_hold;
  logic        lsu_hold;

  int n_cmp = 0;
  int n_err = 0;
  int stall_seen = 0;
  int full_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we     = 1'b0;
    m_sel    = 5'd0;
    m_dat    = 32'd0;
    m_starve = 0;
    m_force  = 1'b0;
    alu_hold = 1'b0;
    lsu_hold = 1'b0;
    i_alu_valid = 1'b0;
    i_alu_rd    = 5'd0;
    i_alu_data  = 32'd0;
    i_lsu_valid = 1'b0;
    i_lsu_rd    = 5'd0;
    i_lsu_data  = 32'd0;
  endtask

  // One clock cycle: check outputs, offer inputs (held if not yet accepted),
  // advance the model by the arbitration rules.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      output logic took_l);
    logic [31:0] exp_pend;
    logic        alu_acc, lsu_acc, do_pop, use_alu;
    int          n;
    ent_t        e;
    @(negedge i_clk);
    exp_pend = 32'd0;
    foreach (mq[k]) begin
      if (mq[k].rd != 5'd0) exp_pend[mq[k].rd] = 1'b1;
    end
    check_eq("write_en", 32'(o_write_en), 32'(m_we));
    check_eq("selectW", 32'(o_selectW), 32'(m_sel));
    check_eq("portW", o_portW, m_dat);
    check_eq("pending", o_pending, exp_pend);
    check_eq("lsu_ready", 32'(o_lsu_ready), 32'(mq.size() < FIFO_DEPTH));
    check_eq("alu_ready", 32'(o_alu_ready), 32'(!m_force));
    if (o_alu_ready == 1'b0) stall_seen++;
    if (o_lsu_ready == 1'b0) full_seen++;

    if (!alu_hold) begin
      i_alu_valid = av;
      i_alu_rd    = ard;
      i_alu_data  = adat;
    end
    took_l = !lsu_hold;
    if (!lsu_hold) begin
      i_lsu_valid = lv;
      i_lsu_rd    = lrd;
      i_lsu_data  = ldat;
    end

    n       = mq.size();
    lsu_acc = i_lsu_valid && (n < FIFO_DEPTH);
    alu_acc = i_alu_valid && !m_force;
    do_pop  = 1'b0;
    use_alu = 1'b0;
    if (m_force && n > 0) do_pop = 1'b1;
    else if (alu_acc) use_alu = 1'b1;
    else if (n > 0) do_pop = 1'b1;

    if (do_pop) begin
      e     = mq.pop_front();
      m_we  = (e.rd != 5'd0);
      m_sel = e.rd;
      m_dat = e.data;
    end else if (use_alu) begin
      m_we  = (i_alu_rd != 5'd0);
      m_sel = i_alu_rd;
      m_dat = i_alu_data;
    end else begin
      m_we = 1'b0;
    end

    if (do_pop) begin
      m_starve = 0;
      m_force  = 1'b0;
    end else if (n == 0) begin
      m_starve = 0;
    end else begin
      m_starve++;
      if (m_starve >= STARVE_LIMIT) m_force = 1'b1;
    end

    if (lsu_acc) mq.push_back({i_lsu_rd, i_lsu_data});
    alu_hold = i_alu_valid && !alu_acc;
    lsu_hold = i_lsu_valid && !lsu_acc;
    @(posedge i_clk);
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t;
    int   lsu_left;
    i_reset = 1'b1;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    idle(2);

    // ALU only
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, t);
    idle(3);

    // LSU only, two back-to-back pushes
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, t);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h22, t);
    idle(5);

    // FIFO full: ALU valid every cycle, three LSU results
    full_seen = 0;
    lsu_left  = 3;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 5'(1 + i), 32'($urandom), lsu_left > 0, 5'(20 + lsu_left),
           32'(lsu_left * 256), t);
      if (t && lsu_left > 0) lsu_left--;
    end
    check_eq("full_seen", 32'(full_seen > 0), 32'd1);
    idle(6);

    // Starvation: ALU continuous, one LSU entry rd=9
    stall_seen = 0;
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 32'h55, t);
    for (int i = 0; i < 8; i++) step(1'b1, 5'(11 + i), 32'(160 + i), 1'b0, 5'd0, 32'd0, t);
    check_eq("starve_stalls", 32'(stall_seen), 32'd1);
    idle(3);

    // x0 results are consumed but never written
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h77, t);
    idle(4);

    // Async reset with two FIFO entries pending and a write staged
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h33, t);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h44, t);
    #2;
    i_reset = 1'b1;
    #1;
    check_eq("rst_write_en", 32'(o_write_en), 32'd0);
    check_eq("rst_selectW", 32'(o_selectW), 32'd0);
    check_eq("rst_portW", o_portW, 32'd0);
    check_eq("rst_pending", o_pending, 32'd0);
    check_eq("rst_lsu_ready", 32'(o_lsu_ready), 32'd1);
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    idle(5);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 10) < 6, 5'($urandom_range(0, 31)), 32'($urandom),
           ($urandom % 10) < 5, 5'($urandom_range(0, 31)), 32'($urandom), t);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side master for the 32x32 register file (x0 hard-wired zero, one write port).
- Merges results from two producers, the single-cycle ALU and the load/store unit (LSU), into the single port (write enable, 5-bit select, 32-bit data). The ALU has priority.
- LSU results are buffered in a small FIFO with starvation protection. A pending-destination bitmap is exported so issue logic can stall on read-after-write hazards.

Parameters:
- FIFO_DEPTH, 2, number of LSU result entries buffered; power of two, ≥2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty LSU FIFO may be bypassed before LSU is forced to win.
- DATA_WIDTH, 32, result/register width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted this cycle if valid
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  DATA_WIDTH  ALU result
- i_lsu_valid  in  1  LSU load result valid
- o_lsu_ready  out  1  FIFO can accept LSU result
- i_lsu_rd  in  5  LSU destination register
- i_lsu_data  in  DATA_WIDTH  LSU result
- o_write_en  out  1  register-file write enable (registered)
- o_selectW  out  5  register-file write select (registered)
- o_portW  out  DATA_WIDTH  register-file write data (registered)
- o_pending  out  32  bit i=1 while any FIFO entry targets register i; bit 0 always 0

Behaviour:
- Reset: async, drives o_write_en=0, o_selectW=0, o_portW=0.
  - FIFO emptied (count=0, pointers=0), starvation counter=0, force_lsu=0, o_pending=0.
  - Reset mid-operation discards all buffered results; no write is issued for them.
- Handshakes: a transfer fires on valid&ready sampled at the rising edge. Producers hold rd/data stable while valid is high and ready is low.
- o_lsu_ready = (count < FIFO_DEPTH), from registered count only.
  - When the FIFO is full, ready is 0 even if a pop occurs in the same cycle (no pass-through when full).
- o_alu_ready = ~force_lsu.
- Per-cycle arbitration, combinational, using current state:
  1. force_lsu and FIFO non-empty -> pop FIFO head.
  2. Else ALU fire -> select ALU.
  3. Else FIFO non-empty -> pop head.
  4. Else idle.
- Output stage, next edge:
  - o_write_en <= selected & (rd != 0).
  - o_selectW / o_portW <= selected rd / data; held unchanged when idle.
  - A result with rd=0 consumes its handshake or pop but never asserts o_write_en.
- Latency:
  - ALU accepted at edge t -> o_write_en high from t to t+1.
  - LSU pushed at edge t is head no earlier than after t; earliest pop at edge t+1; o_write_en high from t+1. There is no bypass around the FIFO.
- Push and pop in the same cycle when non-full: both happen; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. LSU results are written strictly in acceptance order.
- Starvation control:
  - Counter increments each cycle the FIFO is non-empty and no pop occurs.
  - Counter clears on pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, force_lsu=1 from the next cycle until a pop occurs, then clears.
  - While force_lsu=1, ALU ready is low, so the ALU stalls for exactly one cycle per forced pop.
- o_pending is combinational OR of one-hot(rd) over valid FIFO entries, with rd=0 masked.
  - An entry's bit clears in the cycle after its pop edge, when it becomes the output stage.
  - The regfile write lands at the following edge, so issue must treat the output stage as in flight or read through a bypass.
- Ordering between ALU and LSU results to the same rd follows arbitration order. Issue logic must stall on o_pending to avoid WAW inversion.

Test Plan:
- ALU only: rd=5, data=0xDEADBEEF, valid for 1 cycle -> next cycle o_write_en=1, o_selectW=5, o_portW=0xDEADBEEF; then o_write_en=0.
- LSU only:
  - Push rd=7/0x11 then rd=8/0x22 on consecutive edges -> writes 7/0x11 then 8/0x22 on consecutive cycles, starting 2 cycles after the first push.
  - o_pending[7] and o_pending[8] set, then cleared in order.
- FIFO full (DEPTH=2): ALU valid every cycle, LSU pushes 3 results.
  - o_lsu_ready=0 after 2 pushes; third result held by LSU until ready.
  - No data lost; LSU writes in push order.
- Starvation: ALU valid continuously, one LSU entry rd=9/0x55.
  - After 4 bypassed cycles, o_alu_ready=0 for exactly one cycle.
  - rd=9/0x55 is written; ALU resumes next cycle.
- x0 discard: ALU rd=0 data=0xFFFFFFFF and LSU rd=0 -> handshakes complete, o_write_en stays 0, o_pending=0.
- Async reset with 2 FIFO entries pending and an output write staged -> outputs 0 immediately (no clock edge), o_pending=0, o_lsu_ready=1; no stale writes after release.
